// File: rtl/program_loader.sv
// program_loader: takes opcode/operand pairs from a valid/ready stream, encodes each as
// {operand[12:0], opcode[2:0]}, buffers them in a small skid FIFO and writes them in order
// into program memory, holding the core in reset (cpu_rst low) until the program is loaded.
// Optional build macro LOADER_CHECKSUM_EN adds a 16-bit XOR checksum of the words written.
module program_loader #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PROG_LEN = 32,
  parameter int unsigned AW       = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [2:0]    in_opcode,
  input  logic [12:0]   in_operand,
  input  logic          mem_busy,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  output logic          cpu_rst,
  output logic          done,
  output logic [AW:0]   word_count,
`ifdef LOADER_CHECKSUM_EN
  output logic [15:0]   checksum,
`endif
  output logic          overflow
);

  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned WCW = AW + 1;

  localparam logic [CW-1:0]  FifoFull = CW'(DEPTH);
  localparam logic [WCW-1:0] ProgLen  = WCW'(PROG_LEN);
  localparam logic [WCW-1:0] LastIdx  = WCW'(PROG_LEN - 1);
  localparam logic [AW-1:0]  AddrLast = AW'(PROG_LEN - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [15:0]     fifo_q [DEPTH];
  logic [15:0]     fifo_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW:0]     accepted_q, accepted_d;
  logic            mem_wr_q, mem_wr_d;
  logic [15:0]     mem_wdata_q, mem_wdata_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW:0]     word_count_q, word_count_d;
  logic            overflow_q, overflow_d;
  logic            done_q, done_d;
  logic            cpu_rst_q, cpu_rst_d;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0]     checksum_q, checksum_d;
`endif

  logic            fifo_full;
  logic            fifo_empty;
  logic            in_ready_c;
  logic            push;
  logic            pop;
  logic [15:0]     in_word;
  logic            go_load;

  // Handshake and FIFO status, derived from registered state only.
  always_comb begin
    fifo_full  = (count_q == FifoFull);
    fifo_empty = (count_q == '0);
    in_ready_c = (state_q == StLoad) && !fifo_full && (accepted_q < ProgLen);
    push       = in_valid && in_ready_c;
    pop        = ((state_q == StLoad) || (state_q == StDrain)) && !fifo_empty && !mem_busy;
    in_word    = {in_operand, in_opcode};
    go_load    = start && ((state_q == StIdle) || (state_q == StDone));
  end

  // Next-state logic: FIFO, write side, session counters and control FSM.
  always_comb begin
    state_d      = state_q;
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    accepted_d   = accepted_q;
    mem_wr_d     = pop;
    mem_wdata_d  = mem_wdata_q;
    addr_d       = addr_q;
    word_count_d = word_count_q;
    overflow_d   = overflow_q;
    done_d       = done_q;
    cpu_rst_d    = cpu_rst_q;
`ifdef LOADER_CHECKSUM_EN
    checksum_d   = checksum_q;
`endif

    if (push) begin
      fifo_d[wr_ptr_q] = in_word;
      wr_ptr_d         = wr_ptr_q + 1'b1;
      accepted_d       = accepted_q + 1'b1;
    end

    // The popped word is registered and strobed on the following cycle.
    if (pop) begin
      mem_wdata_d = fifo_q[rd_ptr_q];
      rd_ptr_d    = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Address and count advance once the strobe for the current word has gone out.
    if (mem_wr_q) begin
      addr_d       = (addr_q == AddrLast) ? '0 : addr_q + 1'b1;
      word_count_d = word_count_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
      checksum_d   = checksum_q ^ mem_wdata_q;
`endif
    end

    case (state_q)
      StLoad: begin
        if (push && (in_last || (accepted_q == LastIdx))) begin
          state_d = StDrain;
          if (!in_last) begin
            overflow_d = 1'b1;
          end
        end
      end
      StDrain: begin
        if (fifo_empty && !mem_wr_q) begin
          state_d   = StDone;
          done_d    = 1'b1;
          cpu_rst_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (go_load) begin
      state_d      = StLoad;
      accepted_d   = '0;
      addr_d       = '0;
      word_count_d = '0;
      overflow_d   = 1'b0;
      done_d       = 1'b0;
      cpu_rst_d    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum_d   = '0;
`endif
    end
  end

  // State registers with synchronous active-low reset; a reset mid-session abandons it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      accepted_q   <= '0;
      mem_wr_q     <= 1'b0;
      mem_wdata_q  <= '0;
      addr_q       <= '0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
      cpu_rst_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      accepted_q   <= accepted_d;
      mem_wr_q     <= mem_wr_d;
      mem_wdata_q  <= mem_wdata_d;
      addr_q       <= addr_d;
      word_count_q <= word_count_d;
      overflow_q   <= overflow_d;
      done_q       <= done_d;
      cpu_rst_q    <= cpu_rst_d;
`ifdef LOADER_CHECKSUM_EN
      checksum_q   <= checksum_d;
`endif
    end
  end

  // Output drive.
  always_comb begin
    in_ready   = in_ready_c;
    mem_wr     = mem_wr_q;
    mem_addr   = addr_q;
    mem_wdata  = mem_wdata_q;
    cpu_rst    = cpu_rst_q;
    done       = done_q;
    word_count = word_count_q;
    overflow   = overflow_q;
`ifdef LOADER_CHECKSUM_EN
    checksum   = checksum_q;
`endif
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader with a behavioural order/latency model.
module tb_program_loader;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned PROG_LEN = 32;
  localparam int unsigned AW       = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_last = 1'b0;
  logic [2:0]    in_opcode = '0;
  logic [12:0]   in_operand = '0;
  logic          mem_busy = 1'b0;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          cpu_rst;
  logic          done;
  logic [AW:0]   word_count;
  logic          overflow;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0]   checksum;
`endif

  program_loader #(.DEPTH(DEPTH), .PROG_LEN(PROG_LEN), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .in_opcode  (in_opcode),
    .in_operand (in_operand),
    .mem_busy   (mem_busy),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .word_count (word_count),
`ifdef LOADER_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit busy_rand = 0;
  bit rand_gap = 0;

  // Model: words accepted but not yet written, in order, with their accept cycle.
  typedef enum {PhIdle, PhLoad, PhDone} ph_e;
  ph_e         phase = PhIdle;
  logic [15:0] exp_w[$];
  int          exp_c[$];
  int          m_acc = 0;
  int          m_str = 0;
  bit          m_last = 0;
  bit          m_ovf = 0;
  logic [15:0] m_xor = '0;
  logic [15:0] log_d[$];
  int          log_a[$];
  bit          allowed;
  int          pend;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [12:0] opr);
    return {opr, op};
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (busy_rand) mem_busy = ($urandom_range(0, 2) == 0);
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      phase = PhIdle;
      exp_w.delete();
      exp_c.delete();
      m_acc = 0; m_str = 0; m_last = 0; m_ovf = 0; m_xor = '0;
    end else begin
      pend    = exp_w.size();
      allowed = (phase == PhLoad) && !m_last && (m_acc < int'(PROG_LEN));
      if (in_ready) begin
        chk("in_ready_allowed", {31'd0, allowed}, 32'd1);
        chk("fifo_room", {31'd0, (pend - int'(mem_wr)) < int'(DEPTH)}, 32'd1);
      end
      chk("word_count", word_count, m_str);
      chk("cpu_rst_eq_done", cpu_rst, done);
      chk("overflow", overflow, m_ovf);
`ifdef LOADER_CHECKSUM_EN
      chk("checksum", checksum, m_xor);
`endif
      if (done) begin
        chk("done_drained", {31'd0, (pend == 0) && !mem_wr}, 32'd1);
        chk("done_after_end", {31'd0, m_last || (m_acc == int'(PROG_LEN))}, 32'd1);
        chk("done_in_ready", in_ready, 0);
        phase = PhDone;
      end
      if (mem_wr) begin
        chk("strobe_expected", {31'd0, exp_w.size() != 0}, 32'd1);
        if (exp_w.size() != 0) begin
          chk("strobe_data", mem_wdata, exp_w[0]);
          chk("strobe_addr", mem_addr, m_str % int'(PROG_LEN));
          chk("strobe_latency", {31'd0, cyc >= exp_c[0] + 2}, 32'd1);
          void'(exp_w.pop_front());
          void'(exp_c.pop_front());
        end
        log_d.push_back(mem_wdata);
        log_a.push_back(int'(mem_addr));
        m_xor = m_xor ^ mem_wdata;
        m_str++;
      end
      if (in_valid && in_ready) begin
        exp_w.push_back(enc(in_opcode, in_operand));
        exp_c.push_back(cyc);
        m_acc++;
        if (in_last) m_last = 1;
        else if (m_acc == int'(PROG_LEN)) m_ovf = 1;
      end
      if (start && (phase == PhIdle || phase == PhDone)) begin
        phase = PhLoad;
        m_acc = 0; m_str = 0; m_last = 0; m_ovf = 0; m_xor = '0;
        log_d.delete();
        log_a.delete();
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_rst", cpu_rst, 0);
    chk("rst_done", done, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_overflow", overflow, 0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [12:0] opr, input bit last,
                      input int limit, output bit ok);
    ok = 0;
    if (rand_gap) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1; in_opcode = op; in_operand = opr; in_last = last;
    for (int t = 0; t < limit && !ok; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_ok(input logic [2:0] op, input logic [12:0] opr, input bit last);
    bit ok;
    send(op, opr, last, 500, ok);
    if (!ok) chk("send_accepted", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int t = 0; t < 400 && !seen; t++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_reached", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    bit ok;
    int acc, idx, n, nw;
    bit took;

    do_reset();

    // Reset in the middle of a load aborts the session.
    pulse_start();
    for (int i = 0; i < 3; i++) send_ok(3'(i), 13'(i + 1), 1'b0);
    for (int t = 0; t < 50 && m_str < 2; t++) @(posedge clk);
    do_reset();
    repeat (10) @(posedge clk);

    // Three-word program with literal expectations.
    pulse_start();
    send_ok(3'b001, 13'h0005, 1'b0);
    send_ok(3'b010, 13'h0006, 1'b0);
    send_ok(3'b111, 13'h1FFF, 1'b1);
    wait_done();
    chk("p3_count", log_d.size(), 3);
    if (log_d.size() == 3) begin
      chk("p3_w0", log_d[0], 16'h0029);
      chk("p3_w1", log_d[1], 16'h0032);
      chk("p3_w2", log_d[2], 16'hFFFF);
      chk("p3_a0", log_a[0], 0);
      chk("p3_a1", log_a[1], 1);
      chk("p3_a2", log_a[2], 2);
    end
    chk("p3_done", done, 1);
    chk("p3_cpu_rst", cpu_rst, 1);
    chk("p3_word_count", word_count, 3);
`ifdef LOADER_CHECKSUM_EN
    chk("p3_checksum", checksum, 16'hFFE4);
`endif

    // Backpressure: memory busy while the stream keeps offering words.
    mem_busy = 1'b1;
    pulse_start();
    acc = 0; idx = 0;
    in_valid = 1'b1; in_opcode = 3'(idx); in_operand = 13'(13'h100 + idx); in_last = 1'b0;
    repeat (10) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk); #1;
      if (took) begin
        acc++; idx++;
        in_opcode = 3'(idx); in_operand = 13'(13'h100 + idx);
      end
    end
    in_valid = 1'b0;
    chk("bp_accepts", acc, DEPTH);
    mem_busy = 1'b0;
    for (int i = idx; i < 8; i++) send_ok(3'(i), 13'(13'h100 + i), i == 7);
    wait_done();
    chk("bp_total", log_d.size(), 8);
    chk("bp_word_count", word_count, 8);

    // Overflow: 33 words without in_last.
    pulse_start();
    for (int i = 0; i < int'(PROG_LEN); i++) send_ok(3'(i), 13'(i * 7), 1'b0);
    send(3'b101, 13'h0ABC, 1'b0, 12, ok);
    chk("ovf_33rd_refused", {31'd0, ok}, 32'd0);
    wait_done();
    chk("ovf_strobes", log_d.size(), PROG_LEN);
    if (log_a.size() == int'(PROG_LEN)) chk("ovf_last_addr", log_a[PROG_LEN-1], PROG_LEN - 1);
    chk("ovf_flag", overflow, 1);
    chk("ovf_done", done, 1);

    // Re-arm from DONE; a start pulse during LOAD is ignored.
    pulse_start();
    pulse_start();
    send_ok(3'b100, 13'h0042, 1'b1);
    wait_done();
    chk("rearm_count", log_d.size(), 1);
    if (log_a.size() == 1) chk("rearm_addr", log_a[0], 0);
    chk("rearm_word_count", word_count, 1);
    chk("rearm_overflow", overflow, 0);

    // Randomized sessions with random gaps and memory stalls.
    busy_rand = 1; rand_gap = 1;
    for (int s = 0; s < 10; s++) begin
      n  = $urandom_range(1, PROG_LEN + 3);
      nw = (n > int'(PROG_LEN)) ? int'(PROG_LEN) : n;
      pulse_start();
      for (int i = 0; i < nw; i++)
        send_ok(3'($urandom), 13'($urandom), (n <= int'(PROG_LEN)) && (i == n - 1));
      if (n > int'(PROG_LEN)) begin
        send(3'($urandom), 13'($urandom), 1'b0, 10, ok);
        chk("rnd_extra_refused", {31'd0, ok}, 32'd0);
      end
      wait_done();
      chk("rnd_word_count", word_count, nw);
      chk("rnd_overflow", overflow, {31'd0, n > int'(PROG_LEN)});
    end
    busy_rand = 0; rand_gap = 0;

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
